// File: rtl/iob_ethoc_pkg.sv
// Shared types and constants for the iob_ethoc register-port arbiter.
// Holds the arbiter state encoding and the read value returned on abort.
package iob_ethoc_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_W = 1024;

  // Sliced to DATA_W by users; all ones flags an aborted read.
  localparam logic [ARB_MAX_W-1:0] ARB_ERR_DATA = '1;

endpackage

// File: rtl/iob_ethoc_arb_rr.sv
// Two-input round-robin grant; holds which requester was served last.
// Ports: clk, rst (sync, high), req0/req1, upd/upd_gnt, gnt (0=m0), req_any.
module iob_ethoc_arb_rr (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_gnt,
  output logic gnt,
  output logic req_any
);

  logic last;

  // Reset to m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_gnt;
    end
  end

  assign req_any = req0 | req1;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0 & req1:  gnt = ~last;
      ~req0 & req1: gnt = 1'b1;
      default:      gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/iob_ethoc_arb.sv
// Shares the iob_ethoc MAC register port between two IOb masters.
// Ports: m0_*/m1_* IOb slaves, s_* IOb master, timeout_o/timeout_clr_i.
module iob_ethoc_arb
  import iob_ethoc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ready_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ready_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_address_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ready_i,
  output logic                timeout_o,
  input  logic                timeout_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic             g;
  logic             gnt;
  logic             req_any;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             expire;
  logic             fin;
  logic [DATA_W-1:0] rsp;

  assign busy   = (state == ARB_BUSY);
  assign expire = (cnt == CNT_LAST);

  // A reset cycle kills the pending access without completing it.
  assign fin = busy & (s_ready_i | expire) & ~rst_i;

  // MAC response wins a tie with the timeout.
  assign rsp = s_ready_i ? s_rdata_i : ARB_ERR_DATA[DATA_W-1:0];

  assign m0_ready_o = fin & ~g;
  assign m1_ready_o = fin & g;
  assign m0_rdata_o = m0_ready_o ? rsp : '0;
  assign m1_rdata_o = m1_ready_o ? rsp : '0;

  iob_ethoc_arb_rr u_rr (
    .clk     (clk_i),
    .rst     (rst_i),
    .req0    (m0_valid_i),
    .req1    (m1_valid_i),
    .upd     (fin),
    .upd_gnt (g),
    .gnt     (gnt),
    .req_any (req_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ARB_IDLE;
      g           <= 1'b0;
      cnt         <= '0;
      s_valid_o   <= 1'b0;
      s_address_o <= '0;
      s_wdata_o   <= '0;
      s_wstrb_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      // A later set in this block overrides the clear.
      if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
      unique case (state)
        ARB_IDLE: begin
          if (req_any) begin
            state       <= ARB_BUSY;
            g           <= gnt;
            cnt         <= '0;
            s_valid_o   <= 1'b1;
            s_address_o <= gnt ? m1_address_i : m0_address_i;
            s_wdata_o   <= gnt ? m1_wdata_i : m0_wdata_i;
            s_wstrb_o   <= gnt ? m1_wstrb_i : m0_wstrb_i;
          end
        end
        ARB_BUSY: begin
          if (fin) begin
            state     <= ARB_IDLE;
            s_valid_o <= 1'b0;
            if (!s_ready_i) begin
              timeout_o <= 1'b1;
            end
          end else if (!expire) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
